dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (dmem) between the CPU load/store path and a

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/burst_addr_gen.sv | 52 +++++
 rtl/dmem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Package: dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encodings,
// port-owner codes and the byte stride between consecutive burst beats.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    // Loader bursts are word-only, so consecutive beats are one word apart.
    localparam int BEAT_STRIDE = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// Module: burst_addr_gen
// Holds the latched base address and beat counter of a loader burst that is
// continuing past its first beat, and produces the beat address and a
// last-beat flag.
// Ports:
//   clk, reset  clock (rising edge), asynchronous active-high reset
//   start       beat 0 executing and the burst continues: latch base/len, beat=1
//   advance     a continuation beat executes this cycle
//   start_addr  burst base address (beat 0 address)
//   start_len   clamped burst length in beats
//   addr        base + 4*beat, wrapping modulo 2^AW
//   last        current beat is the final one of the burst
module burst_addr_gen
    import dmem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               advance,
    input  logic [AW-1:0]      start_addr,
    input  logic [BURST_W-1:0] start_len,
    output logic [AW-1:0]      addr,
    output logic               last
);

    logic [AW-1:0]      base_q;
    logic [BURST_W-1:0] beat_q;
    logic [BURST_W-1:0] len_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            beat_q <= '0;
            len_q  <= '0;
        end else if (start) begin
            base_q <= start_addr;
            beat_q <= BURST_W'(1);
            len_q  <= start_len;
        end else if (advance) begin
            beat_q <= last ? '0 : beat_q + BURST_W'(1);
        end
    end

    assign addr = base_q + AW'(BEAT_STRIDE) * AW'(beat_q);
    assign last = (beat_q == len_q - BURST_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Module: dmem_arbiter
// Shares the single dmem port between the CPU load/store path (one-cycle
// accesses, combinational read data) and a word-burst loader that owns the
// port for N consecutive cycles once started. A CPU that loses arbitration
// sees cpu_stall=1.
// Configuration macro: DMEM_ARB_RR_EN
//   undefined - CPU has strict priority on an IDLE conflict
//   defined   - IDLE conflicts alternate, starting with the CPU after reset
// Ports:
//   cpu_addr/cpu_wdata/cpu_we_b/cpu_we_w/cpu_re_b/cpu_re_w  CPU access
//   cpu_rdata  combinational copy of mem_rdata
//   cpu_stall  CPU access pending but not granted this cycle
//   ld_req/ld_addr/ld_we/ld_burst/ld_wdata  loader burst request and data
//   ld_gnt     loader beat executing this cycle
//   ld_rvalid/ld_rdata  registered read word, one cycle after a read beat
//   ld_done    one-cycle pulse after the final beat
//   mem_*      dmem port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8,
    parameter int BURST_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    input  logic               cpu_we_b,
    input  logic               cpu_we_w,
    input  logic               cpu_re_b,
    input  logic               cpu_re_w,
    output logic [DW-1:0]      cpu_rdata,
    output logic               cpu_stall,
    input  logic               ld_req,
    input  logic [AW-1:0]      ld_addr,
    input  logic               ld_we,
    input  logic [BURST_W-1:0] ld_burst,
    input  logic [DW-1:0]      ld_wdata,
    output logic               ld_gnt,
    output logic               ld_rvalid,
    output logic [DW-1:0]      ld_rdata,
    output logic               ld_done,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we_b,
    output logic               mem_we_w,
    output logic               mem_re_b,
    output logic               mem_re_w,
    input  logic [DW-1:0]      mem_rdata
);

    localparam logic [BURST_W-1:0] MAX_LEN = BURST_W'(MAX_BURST);

    logic               cpu_req;
    state_t             state_q, state_d;
    owner_t             owner;
    logic               ld_we_q;
    logic               ld_we_eff;
    logic [BURST_W-1:0] len_req;
    logic               ag_start, ag_advance, ag_last;
    logic [AW-1:0]      ag_addr;
    logic               final_beat;
    logic               beat_read;
`ifdef DMEM_ARB_RR_EN
    owner_t             rr_last_q, rr_last_d;
`endif

    assign cpu_req   = cpu_we_b | cpu_we_w | cpu_re_b | cpu_re_w;
    assign cpu_rdata = mem_rdata;

    // Beat 0 comes straight from the request; later beats use the latched direction.
    assign ld_we_eff = (state_q == ST_BURST) ? ld_we_q : ld_we;
    assign beat_read = (owner == OWN_LD) && !ld_we_eff;

    always_comb begin
        if (ld_burst == '0)
            len_req = BURST_W'(1);
        else if (ld_burst > MAX_LEN)
            len_req = MAX_LEN;
        else
            len_req = ld_burst;
    end

    burst_addr_gen #(
        .AW      (AW),
        .BURST_W (BURST_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .start      (ag_start),
        .advance    (ag_advance),
        .start_addr (ld_addr),
        .start_len  (len_req),
        .addr       (ag_addr),
        .last       (ag_last)
    );

    // Arbitration and next state.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        owner      = OWN_NONE;
        ag_start   = 1'b0;
        ag_advance = 1'b0;
        final_beat = 1'b0;
`ifdef DMEM_ARB_RR_EN
        rr_last_d  = rr_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cpu_req && ld_req) begin
`ifdef DMEM_ARB_RR_EN
                    // Give the conflict to whoever did not win the previous one.
                    owner     = (rr_last_q == OWN_CPU) ? OWN_LD : OWN_CPU;
                    rr_last_d = owner;
`else
                    owner = OWN_CPU;
`endif
                end else if (cpu_req) begin
                    owner = OWN_CPU;
                end else if (ld_req) begin
                    owner = OWN_LD;
                end
                if (owner == OWN_LD) begin
                    if (len_req > BURST_W'(1)) begin
                        ag_start = 1'b1;
                        state_d  = ST_BURST;
                    end else begin
                        final_beat = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                owner      = OWN_LD;
                ag_advance = 1'b1;
                if (ag_last) begin
                    final_beat = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Port mux; everything toward dmem and the requesters is quiet during reset.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we_b  = 1'b0;
        mem_we_w  = 1'b0;
        mem_re_b  = 1'b0;
        mem_re_w  = 1'b0;
        ld_gnt    = 1'b0;
        cpu_stall = 1'b0;
        if (!reset) begin
            cpu_stall = cpu_req && (owner != OWN_CPU);
            case (owner)
                OWN_CPU: begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_we_b  = cpu_we_b;
                    mem_we_w  = cpu_we_w;
                    mem_re_b  = cpu_re_b;
                    mem_re_w  = cpu_re_w;
                end
                OWN_LD: begin
                    mem_addr  = (state_q == ST_BURST) ? ag_addr : ld_addr;
                    mem_wdata = ld_wdata;
                    mem_we_w  = ld_we_eff;
                    mem_re_w  = !ld_we_eff;
                    ld_gnt    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ld_we_q   <= 1'b0;
            ld_done   <= 1'b0;
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            state_q   <= state_d;
            ld_done   <= final_beat;
            ld_rvalid <= beat_read;
            if (ag_start)
                ld_we_q <= ld_we;
            if (beat_read)
                ld_rdata <= mem_rdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_last_q <= OWN_NONE;
        else
            rr_last_q <= rr_last_d;
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench: tb_dmem_arbiter
// Drives directed and randomized traffic into dmem_arbiter and compares every
// cycle against a transaction-level model: a granted loader burst is expanded
// into a queue of planned beats (address, direction, last flag) that are
// consumed one per cycle; the CPU only reaches the port when the queue is empty.
// Honors DMEM_ARB_RR_EN the same way as the design.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we_b, cpu_we_w, cpu_re_b, cpu_re_w, cpu_stall;
    logic        ld_req, ld_we, ld_gnt, ld_rvalid, ld_done;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic [3:0]  ld_burst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we_b, mem_we_w, mem_re_b, mem_re_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we_b  (cpu_we_b),
        .cpu_we_w  (cpu_we_w),
        .cpu_re_b  (cpu_re_b),
        .cpu_re_w  (cpu_re_w),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_we     (ld_we),
        .ld_burst  (ld_burst),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .ld_done   (ld_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we_b  (mem_we_b),
        .mem_we_w  (mem_we_w),
        .mem_re_b  (mem_re_b),
        .mem_re_w  (mem_re_w),
        .mem_rdata (mem_rdata)
    );

    // Everything observable in one cycle. Address/write data only matter when
    // a strobe uses them, so they are zeroed otherwise on both sides.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we_b, we_w, re_b, re_w;
        logic        stall, gnt;
        logic [31:0] crd;
        logic        done, rvalid;
        logic [31:0] rdata;
    } obs_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        last;
    } beat_t;

    // Reference model state.
    beat_t       plan[$];
    logic        m_done, m_rvalid;
    logic [31:0] m_rdata;
    bit          rr_cpu_won_last;

    task automatic sample(output obs_t o);
        o        = '0;
        o.we_b   = mem_we_b;
        o.we_w   = mem_we_w;
        o.re_b   = mem_re_b;
        o.re_w   = mem_re_w;
        o.addr   = (mem_we_b | mem_we_w | mem_re_b | mem_re_w) ? mem_addr : 32'h0;
        o.wdata  = (mem_we_b | mem_we_w) ? mem_wdata : 32'h0;
        o.stall  = cpu_stall;
        o.gnt    = ld_gnt;
        o.crd    = cpu_rdata;
        o.done   = ld_done;
        o.rvalid = ld_rvalid;
        o.rdata  = ld_rdata;
    endtask

    // One model cycle: expected outputs for the inputs currently applied,
    // then advance the model's registered expectations.
    task automatic model_cycle(output obs_t e);
        bit    creq, ld_wins;
        int    len;
        beat_t b;
        e     = '0;
        e.crd = mem_rdata;
        if (reset) begin
            plan.delete();
            m_done = 0; m_rvalid = 0; m_rdata = 0;
            rr_cpu_won_last = 0;
            return;
        end
        e.done   = m_done;
        e.rvalid = m_rvalid;
        e.rdata  = m_rdata;
        creq     = cpu_we_b | cpu_we_w | cpu_re_b | cpu_re_w;
        if (plan.size() == 0) begin
            ld_wins = 0;
            if (creq && ld_req) begin
`ifdef DMEM_ARB_RR_EN
                ld_wins = rr_cpu_won_last;
                rr_cpu_won_last = !ld_wins;
`endif
            end else if (ld_req) begin
                ld_wins = 1;
            end
            if (ld_wins) begin
                len = (ld_burst == 0) ? 1 : ((int'(ld_burst) > 8) ? 8 : int'(ld_burst));
                for (int k = 0; k < len; k++) begin
                    b.addr = ld_addr + 32'(4 * k);
                    b.we   = ld_we;
                    b.last = (k == len - 1);
                    plan.push_back(b);
                end
            end
        end
        m_done = 0; m_rvalid = 0;
        if (plan.size() > 0) begin
            b       = plan.pop_front();
            e.gnt   = 1;
            e.stall = creq;
            e.addr  = b.addr;
            e.we_w  = b.we;
            e.re_w  = !b.we;
            e.wdata = b.we ? ld_wdata : 32'h0;
            m_done  = b.last;
            if (!b.we) begin
                m_rvalid = 1;
                m_rdata  = mem_rdata;
            end
        end else if (creq) begin
            e.addr  = cpu_addr;
            e.wdata = (cpu_we_b | cpu_we_w) ? cpu_wdata : 32'h0;
            e.we_b  = cpu_we_b; e.we_w = cpu_we_w;
            e.re_b  = cpu_re_b; e.re_w = cpu_re_w;
        end
    endtask

    task automatic quiet_inputs();
        cpu_addr = 0; cpu_wdata = 0;
        {cpu_we_b, cpu_we_w, cpu_re_b, cpu_re_w} = 4'b0;
        ld_req = 0; ld_addr = 0; ld_we = 0; ld_burst = 0; ld_wdata = 0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        quiet_inputs();
        cpu_re_w = 1; ld_req = 1; ld_burst = 4'd3; mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", c, o, e);
            end
        end
        @(negedge clk); reset = 0; quiet_inputs();
    endtask

    task automatic test_cpu_only();
        obs_t o, e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            if (c == 0) begin
                cpu_addr = 32'h40; cpu_re_w = 1;
            end else begin
                cpu_addr = $urandom; cpu_wdata = $urandom;
                {cpu_we_b, cpu_we_w, cpu_re_b, cpu_re_w} = 4'($urandom_range(1, 15));
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL cpu_only cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_write_burst();
        obs_t o, e;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            ld_wdata  = $urandom;
            if (c == 0) begin
                ld_req = 1; ld_we = 1; ld_addr = 32'h100; ld_burst = 4'd4;
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL write_burst cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_fixed_conflict();
        obs_t o, e;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            ld_req = (c < 4); ld_we = 0; ld_addr = 32'h200; ld_burst = 4'd2;
            if (c < 3) begin
                cpu_addr = 32'h80 + 32'(c * 4); cpu_re_w = 1;
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL conflict cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_cpu_during_burst();
        obs_t o, e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            ld_wdata  = $urandom;
            if (c == 0) begin
                ld_req = 1; ld_we = 1; ld_addr = 32'h300; ld_burst = 4'd3;
            end
            if (c >= 1 && c <= 3) begin
                cpu_we_w = 1; cpu_addr = 32'h44; cpu_wdata = 32'hCAFE_0001;
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL cpu_in_burst cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_clamp_wrap();
        obs_t o, e;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            if (c == 0) begin
                ld_req = 1; ld_we = 0; ld_addr = 32'hFFFF_FFF8; ld_burst = 4'd15;
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clamp_wrap cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        obs_t o, e;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            if (c == 0) begin
                ld_req = 1; ld_we = 0; ld_addr = 32'h500; ld_burst = 4'd6;
            end
            reset = (c == 2 || c == 3);
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_burst cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_back_to_back_conflicts();
        obs_t o, e;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            ld_wdata  = $urandom;
            // Two conflicts in a row; the single-beat loader request stays up.
            ld_req = (c < 3); ld_we = 1; ld_addr = 32'h600; ld_burst = 4'd0;
            if (c < 2) begin
                cpu_re_b = 1; cpu_addr = 32'h700 + 32'(c);
            end
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_conflict cyc=%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            quiet_inputs();
            mem_rdata = $urandom;
            cpu_addr  = $urandom; cpu_wdata = $urandom;
            if ($urandom_range(0, 99) < 40)
                {cpu_we_b, cpu_we_w, cpu_re_b, cpu_re_w} = 4'($urandom_range(1, 15));
            ld_req   = ($urandom_range(0, 99) < 35);
            ld_we    = 1'($urandom);
            ld_addr  = $urandom & 32'hFFFF_FFFC;
            ld_burst = 4'($urandom);
            ld_wdata = $urandom;
            reset    = ($urandom_range(0, 199) == 0);
            #1;
            sample(o); model_cycle(e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, o, e);
            end
        end
        @(negedge clk); reset = 0;
    endtask

    initial begin
        quiet_inputs();
        mem_rdata = 0;
        plan.delete();
        m_done = 0; m_rvalid = 0; m_rdata = 0; rr_cpu_won_last = 0;
        test_reset();
        test_cpu_only();
        test_write_burst();
        test_fixed_conflict();
        test_cpu_during_burst();
        test_clamp_wrap();
        test_reset_mid_burst();
        test_back_to_back_conflicts();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
